// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared OAM/DMA constants and the DMA engine state type.
package oam_dma_pkg;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_LOC      = 16'hFE00;
    localparam int          OAM_SIZE     = 160;
    typedef enum logic [2:0] {IDLE, START, RD, CAP, WR, GAP} DmaState;
endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU data-bus responder port and the DMA bus-master port.
interface oam_db_if;
    logic [15:0] addr;
    logic [7:0]  wdata, rdata;
    logic        rd, wr, rdata_oe;
    modport slave(input addr, wdata, rd, wr, output rdata, rdata_oe);
    modport cpu(output addr, wdata, rd, wr, input rdata, rdata_oe);
endinterface

interface oam_dma_if;
    logic        req, gnt, rd, wr;
    logic [15:0] addr;
    logic [7:0]  wdata, rdata;
    modport master(output req, rd, wr, addr, wdata, input gnt, rdata);
    modport arb(input req, rd, wr, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/oam_dma.sv
// oam_dma: copies 160 bytes from {src,8'h00} into OAM when 0xFF46 is written,
// one byte per RD/CAP/WR/GAP sequence, stalling whenever the bus grant is low.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int DMA_LEN     = OAM_SIZE,
    parameter int BYTE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    oam_db_if.slave    db,
    oam_dma_if.master  m,
    output logic       dma_active
);
    if (BYTE_CYCLES != 4) begin : g_cycles_check
        $error("oam_dma sequences exactly 4 clocks per byte");
    end

    DmaState    state_q, state_d;
    logic [7:0] src_q, idx_q, idx_d, byte_q, byte_d, rdata_q, eff_src;
    logic       oe_q, reg_wr, reg_rd, last;

    assign reg_wr  = db.wr && db.addr == DMA_REG_ADDR;
    assign reg_rd  = db.rd && db.addr == DMA_REG_ADDR;
    // 0xE000-0xFDFF echoes work RAM at 0xC000
    assign eff_src = src_q >= 8'hE0 ? src_q - 8'h20 : src_q;
    assign last    = idx_q == 8'(DMA_LEN - 1);

    assign db.rdata    = rdata_q;
    assign db.rdata_oe = oe_q;
    assign dma_active  = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= 8'hFF;
            idx_q   <= 8'h00;
            byte_q  <= 8'h00;
            rdata_q <= 8'h00;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            oe_q    <= reg_rd;
            if (reg_wr) src_q <= db.wdata;
            if (reg_rd) rdata_q <= src_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        m.req   = state_q != IDLE;
        m.rd    = 1'b0;
        m.wr    = 1'b0;
        m.addr  = 16'h0000;
        m.wdata = 8'h00;
        case (state_q)
            START: state_d = RD;
            RD: begin
                m.addr  = {eff_src, idx_q};
                m.rd    = m.gnt;
                state_d = m.gnt ? CAP : RD;
            end
            CAP: begin
                m.addr  = {eff_src, idx_q};
                byte_d  = m.gnt ? m.rdata : byte_q;
                state_d = m.gnt ? WR : CAP;
            end
            WR: begin
                m.addr  = {OAM_LOC[15:8], idx_q};
                m.wr    = m.gnt;
                m.wdata = byte_q;
                state_d = m.gnt ? GAP : WR;
            end
            GAP: begin
                state_d = !m.gnt ? GAP : last ? IDLE : RD;
                idx_d   = !m.gnt ? idx_q : last ? 8'h00 : idx_q + 8'h01;
            end
            default: ;
        endcase
        // a register write restarts from byte 0, dropping any byte in flight
        if (reg_wr) begin
            state_d = START;
            idx_d   = 8'h00;
        end
    end
endmodule
